// File: rtl/phase_accumulator_glide.sv
// phase_accumulator_glide: oscillator phase accumulator with exponential glide and hard sync
module phase_accumulator_glide #(
  parameter int PHASE_W = 32,
  parameter int GLIDE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_en,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_load,
  input  logic [GLIDE_W-1:0] glide_rate,
  input  logic               sync_in,
  output logic [PHASE_W-1:0] phase,
  output logic [PHASE_W-1:0] cur_inc,
  output logic               wrap,
  output logic               gliding
);
  logic [PHASE_W-1:0] phase_q, phase_d, cur_inc_q, cur_inc_d, target_q, target_d;
  logic               wrap_q, wrap_d, gliding_q, gliding_d, sync_pend_q, sync_pend_d;
  logic signed [PHASE_W:0] diff, step;
  logic [PHASE_W:0]   mag, sum;
  logic               snap, do_sync;
  // glide step toward target, then phase advance / sync / wrap for this edge
  always_comb begin
    diff        = $signed({1'b0, target_q}) - $signed({1'b0, cur_inc_q});
    mag         = diff[PHASE_W] ? $unsigned(-diff) : $unsigned(diff);
    step        = diff >>> glide_rate;
    snap        = (glide_rate == '0) || ((mag >> glide_rate) == '0);
    cur_inc_d   = !sample_en ? cur_inc_q : snap ? target_q : cur_inc_q + step[PHASE_W-1:0];
    target_d    = freq_load ? freq_word : target_q;
    do_sync     = sync_in | sync_pend_q;
    sum         = {1'b0, phase_q} + {1'b0, cur_inc_q};
    phase_d     = !sample_en ? phase_q : do_sync ? '0 : sum[PHASE_W-1:0];
    wrap_d      = sample_en & ~do_sync & sum[PHASE_W];
    sync_pend_d = sample_en ? 1'b0 : (sync_pend_q | sync_in);
    gliding_d   = cur_inc_d != target_d;
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      cur_inc_q   <= '0;
      target_q    <= '0;
      wrap_q      <= 1'b0;
      gliding_q   <= 1'b0;
      sync_pend_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cur_inc_q   <= cur_inc_d;
      target_q    <= target_d;
      wrap_q      <= wrap_d;
      gliding_q   <= gliding_d;
      sync_pend_q <= sync_pend_d;
    end
  end
  assign phase   = phase_q;
  assign cur_inc = cur_inc_q;
  assign wrap    = wrap_q;
  assign gliding = gliding_q;
endmodule

// File: tb/tb_phase_accumulator_glide.sv
// tb_phase_accumulator_glide: directed vector table plus glide/sync/reset sequences
module tb_phase_accumulator_glide;
  logic        clk = 1'b0, rst_n = 1'b0, sample_en = 1'b0, freq_load = 1'b0, sync_in = 1'b0;
  logic [31:0] freq_word = '0;
  logic [3:0]  glide_rate = '0;
  logic [31:0] phase, cur_inc;
  logic        wrap, gliding;
  int          tests = 0, fails = 0;

  typedef struct {
    logic        rst;
    logic        se, fl;
    logic [31:0] fw;
    logic [3:0]  gr;
    logic        sy;
    logic [31:0] ph, ci;
    logic        wr, gl;
  } vec_t;
  vec_t vecs[19];

  phase_accumulator_glide dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .freq_word(freq_word),
    .freq_load(freq_load), .glide_rate(glide_rate), .sync_in(sync_in),
    .phase(phase), .cur_inc(cur_inc), .wrap(wrap), .gliding(gliding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic se);
    sample_en = se;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic arst();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] prev;
  logic [31:0] exp_up[3];

  initial begin
    vecs[0]  = '{0, 0, 1, 32'h4000_0000, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 1};
    vecs[1]  = '{0, 1, 0, 32'h0,         0, 0, 32'h0000_0000, 32'h4000_0000, 0, 0};
    vecs[2]  = '{0, 1, 0, 32'h0,         0, 0, 32'h4000_0000, 32'h4000_0000, 0, 0};
    vecs[3]  = '{0, 1, 0, 32'h0,         0, 0, 32'h8000_0000, 32'h4000_0000, 0, 0};
    vecs[4]  = '{0, 1, 0, 32'h0,         0, 0, 32'hC000_0000, 32'h4000_0000, 0, 0};
    vecs[5]  = '{0, 1, 0, 32'h0,         0, 0, 32'h0000_0000, 32'h4000_0000, 1, 0};
    vecs[6]  = '{0, 0, 0, 32'h0,         0, 0, 32'h0000_0000, 32'h4000_0000, 0, 0};
    vecs[7]  = '{1, 0, 1, 32'h1234_5678, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 1};
    vecs[8]  = '{0, 1, 0, 32'h0,         0, 0, 32'h0000_0000, 32'h1234_5678, 0, 0};
    vecs[9]  = '{0, 1, 0, 32'h0,         0, 0, 32'h1234_5678, 32'h1234_5678, 0, 0};
    vecs[10] = '{0, 0, 0, 32'h0,         0, 1, 32'h1234_5678, 32'h1234_5678, 0, 0};
    vecs[11] = '{0, 0, 0, 32'h0,         0, 1, 32'h1234_5678, 32'h1234_5678, 0, 0};
    vecs[12] = '{0, 1, 0, 32'h0,         0, 0, 32'h0000_0000, 32'h1234_5678, 0, 0};
    vecs[13] = '{0, 1, 0, 32'h0,         0, 0, 32'h1234_5678, 32'h1234_5678, 0, 0};
    vecs[14] = '{0, 1, 0, 32'h0,         0, 1, 32'h0000_0000, 32'h1234_5678, 0, 0};
    vecs[15] = '{0, 1, 0, 32'h0,         0, 0, 32'h1234_5678, 32'h1234_5678, 0, 0};
    vecs[16] = '{0, 0, 1, 32'h2000_0000, 0, 0, 32'h1234_5678, 32'h1234_5678, 0, 1};
    vecs[17] = '{0, 1, 0, 32'h0,         0, 0, 32'h2468_ACF0, 32'h2000_0000, 0, 0};
    vecs[18] = '{0, 1, 0, 32'h0,         0, 0, 32'h4468_ACF0, 32'h2000_0000, 0, 0};
    exp_up = '{32'h100, 32'h1F0, 32'h2D1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", phase, 0);
    chk("rst_cur_inc", cur_inc, 0);
    chk("rst_wrap", {31'b0, wrap}, 0);
    chk("rst_gliding", {31'b0, gliding}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].rst) arst();
      sample_en  = vecs[i].se;
      freq_load  = vecs[i].fl;
      freq_word  = vecs[i].fw;
      glide_rate = vecs[i].gr;
      sync_in    = vecs[i].sy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_phase", i), phase, vecs[i].ph);
      chk($sformatf("v%0d_cur_inc", i), cur_inc, vecs[i].ci);
      chk($sformatf("v%0d_wrap", i), {31'b0, wrap}, {31'b0, vecs[i].wr});
      chk($sformatf("v%0d_gliding", i), {31'b0, gliding}, {31'b0, vecs[i].gl});
    end
    sync_in = 1'b0;
    freq_load = 1'b0;

    // upward glide, strobe every 4th cycle
    arst();
    glide_rate = 4'd4;
    freq_word = 32'h1000;
    freq_load = 1'b1;
    tick(1'b0);
    freq_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      chk($sformatf("up_step%0d", i), cur_inc, exp_up[i]);
      chk($sformatf("up_glide%0d", i), {31'b0, gliding}, 1);
      repeat (3) tick(1'b0);
      chk($sformatf("up_hold%0d", i), cur_inc, exp_up[i]);
    end
    for (int n = 0; n < 200 && gliding; n++) begin
      prev = cur_inc;
      tick(1'b1);
      chk("up_mono", {31'b0, (cur_inc >= prev) && (cur_inc <= 32'h1000)}, 1);
      repeat (3) tick(1'b0);
    end
    chk("up_final", cur_inc, 32'h1000);
    chk("up_done", {31'b0, gliding}, 0);

    // downward glide to zero
    freq_word = 32'h0;
    freq_load = 1'b1;
    tick(1'b0);
    freq_load = 1'b0;
    chk("dn_start_glide", {31'b0, gliding}, 1);
    tick(1'b1);
    chk("dn_step0", cur_inc, 32'hF00);
    for (int n = 0; n < 200 && gliding; n++) begin
      prev = cur_inc;
      tick(1'b1);
      chk("dn_mono", {31'b0, cur_inc <= prev}, 1);
      repeat (3) tick(1'b0);
    end
    chk("dn_final", cur_inc, 32'h0);
    chk("dn_done", {31'b0, gliding}, 0);

    // retarget on the same edge as a strobe
    freq_word = 32'h1000;
    freq_load = 1'b1;
    tick(1'b0);
    freq_load = 1'b0;
    tick(1'b1);
    chk("rt_step0", cur_inc, 32'h100);
    freq_word = 32'h0;
    freq_load = 1'b1;
    tick(1'b1);
    freq_load = 1'b0;
    chk("rt_old_target", cur_inc, 32'h1F0);
    chk("rt_gliding", {31'b0, gliding}, 1);
    tick(1'b1);
    chk("rt_new_target", cur_inc, 32'h1D1);

    // asynchronous reset mid-glide
    freq_word = 32'h1000;
    freq_load = 1'b1;
    tick(1'b0);
    freq_load = 1'b0;
    tick(1'b1);
    tick(1'b1);
    chk("ar_pre_glide", {31'b0, gliding}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_phase", phase, 0);
    chk("ar_cur_inc", cur_inc, 0);
    chk("ar_wrap", {31'b0, wrap}, 0);
    chk("ar_gliding", {31'b0, gliding}, 0);
    rst_n = 1'b1;
    tick(1'b1);
    chk("ar_post_cur_inc", cur_inc, 0);
    chk("ar_post_gliding", {31'b0, gliding}, 0);
    chk("ar_post_phase", phase, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
